// File: rtl/rv32i_instr_decoder_pkg.sv
// Shared definitions for the RV32I decode stage: opcode constants,
// immediate-format selector and the packed record of registered decode results.
package rv32i_instr_decoder_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Which RV32I immediate layout to extract from the instruction word.
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   // Everything the execute stage receives one cycle after decode.
   typedef struct packed {
      logic        is_store;
      logic        is_load;
      logic        is_branch;
      logic        is_jump;
      logic        is_reg;
      logic        is_alu;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
      logic [31:0] branch_dest;
      logic [4:0]  dest;
      logic [2:0]  func3;
      logic        func7;
   } dec_out_t;

   // Shift-immediate forms of OP-IMM carry a shamt instead of an I-immediate.
   function automatic logic is_shift_imm(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b101);
   endfunction

endpackage

// File: rtl/rv32i_instr_decoder_if.sv
// Decode-stage bus: instruction and register-file data in, read addresses
// and registered decode results out.
interface rv32i_instr_decoder_if;
   logic [31:0] instr;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic        is_store;
   logic        is_load;
   logic        is_branch;
   logic        is_jump;
   logic        is_reg;
   logic        is_alu;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] branch_dest;
   logic [4:0]  dest;
   logic [2:0]  func3;
   logic        func7;

   // Fetch / register-file side.
   modport master (
      output instr, rdata1, rdata2,
      input  raddr1, raddr2,
      input  is_store, is_load, is_branch, is_jump, is_reg, is_alu,
      input  operand_a, operand_b, branch_dest, dest, func3, func7
   );

   // Decoder side.
   modport slave (
      input  instr, rdata1, rdata2,
      output raddr1, raddr2,
      output is_store, is_load, is_branch, is_jump, is_reg, is_alu,
      output operand_a, operand_b, branch_dest, dest, func3, func7
   );
endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the RV32I
// I/S/B/U/J immediates. Only instr[31:7] carries immediate bits.
module rv32i_imm_gen
   import rv32i_instr_decoder_pkg::*;
(
   input  logic [31:7] instr_i,
   input  imm_fmt_e    fmt_i,
   output logic [31:0] imm_o
);

   // Assemble the immediate for the selected format; B and J get the implicit zero LSB.
   always_comb begin
      imm_o = 32'h0000_0000;
      case (fmt_i)
         IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   imm_o = {instr_i[31:12], 12'h000};
         IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         default: imm_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/rv32i_instr_decoder.sv
// Registered RV32I decode stage. Register-file read addresses are combinational
// so read data returns in the same cycle; all decode results are registered.
module rv32i_instr_decoder
   import rv32i_instr_decoder_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   rv32i_instr_decoder_if.slave  dec_if
);

   logic [6:0]  opcode_s;
   logic [2:0]  f3_s;
   logic [4:0]  rd_s;
   imm_fmt_e    fmt_s;
   logic [31:0] imm_s;
   dec_out_t    dec_d;
   dec_out_t    dec_q;

   assign opcode_s = dec_if.instr[6:0];
   assign f3_s     = dec_if.instr[14:12];
   assign rd_s     = dec_if.instr[11:7];

   // Read addresses are held at x0 while reset is asserted.
   assign dec_if.raddr1 = reset ? dec_if.instr[19:15] : 5'd0;
   assign dec_if.raddr2 = reset ? dec_if.instr[24:20] : 5'd0;

   rv32i_imm_gen u_imm_gen (
      .instr_i (dec_if.instr[31:7]),
      .fmt_i   (fmt_s),
      .imm_o   (imm_s)
   );

   // Pick the immediate layout implied by the opcode.
   always_comb begin
      fmt_s = IMM_NONE;
      case (opcode_s)
         OPC_JAL:    fmt_s = IMM_J;
         OPC_JALR:   fmt_s = IMM_I;
         OPC_BRANCH: fmt_s = IMM_B;
         OPC_LOAD:   fmt_s = IMM_I;
         OPC_STORE:  fmt_s = IMM_S;
         OPC_OP_IMM: fmt_s = IMM_I;
         OPC_LUI:    fmt_s = IMM_U;
         OPC_AUIPC:  fmt_s = IMM_U;
         default:    fmt_s = IMM_NONE;
      endcase
   end

   // Next-state decode; any field not set for an opcode stays zero.
   always_comb begin
      dec_d = '0;
      case (opcode_s)
         OPC_JAL: begin
            dec_d.is_jump   = 1'b1;
            dec_d.operand_a = imm_s;
            dec_d.dest      = rd_s;
         end
         OPC_JALR: begin
            dec_d.is_jump   = 1'b1;
            dec_d.is_reg    = 1'b1;
            dec_d.operand_a = dec_if.rdata1;
            dec_d.operand_b = imm_s;
            dec_d.dest      = rd_s;
            dec_d.func3     = f3_s;
         end
         OPC_BRANCH: begin
            dec_d.is_branch   = 1'b1;
            dec_d.operand_a   = dec_if.rdata1;
            dec_d.operand_b   = dec_if.rdata2;
            dec_d.branch_dest = imm_s;
            dec_d.func3       = f3_s;
         end
         OPC_LOAD: begin
            dec_d.is_load   = 1'b1;
            dec_d.operand_a = dec_if.rdata1;
            dec_d.operand_b = imm_s;
            dec_d.dest      = rd_s;
            dec_d.func3     = f3_s;
         end
         OPC_STORE: begin
            dec_d.is_store    = 1'b1;
            dec_d.operand_a   = dec_if.rdata1;
            dec_d.operand_b   = dec_if.rdata2;
            dec_d.branch_dest = imm_s;
            dec_d.func3       = f3_s;
         end
         OPC_OP_IMM: begin
            dec_d.is_alu    = 1'b1;
            dec_d.operand_a = dec_if.rdata1;
            dec_d.dest      = rd_s;
            dec_d.func3     = f3_s;
            if (is_shift_imm(f3_s)) begin
               dec_d.operand_b = {27'd0, dec_if.instr[24:20]};
               dec_d.func7     = dec_if.instr[30];
            end else begin
               dec_d.operand_b = imm_s;
               dec_d.func7     = 1'b0;
            end
         end
         OPC_OP: begin
            dec_d.is_alu    = 1'b1;
            dec_d.is_reg    = 1'b1;
            dec_d.operand_a = dec_if.rdata1;
            dec_d.operand_b = dec_if.rdata2;
            dec_d.dest      = rd_s;
            dec_d.func3     = f3_s;
            dec_d.func7     = dec_if.instr[30];
         end
         OPC_LUI: begin
            dec_d.is_alu    = 1'b1;
            dec_d.operand_b = imm_s;
            dec_d.func3     = 3'b000;
            dec_d.dest      = rd_s;
         end
         OPC_AUIPC: begin
            dec_d.operand_a = imm_s;
            dec_d.dest      = rd_s;
         end
         default: dec_d = '0;
      endcase
   end

   // Pipeline register toward execute; reset wins over decode on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dec_q <= '0;
      end else begin
         dec_q <= dec_d;
      end
   end

   assign dec_if.is_store    = dec_q.is_store;
   assign dec_if.is_load     = dec_q.is_load;
   assign dec_if.is_branch   = dec_q.is_branch;
   assign dec_if.is_jump     = dec_q.is_jump;
   assign dec_if.is_reg      = dec_q.is_reg;
   assign dec_if.is_alu      = dec_q.is_alu;
   assign dec_if.operand_a   = dec_q.operand_a;
   assign dec_if.operand_b   = dec_q.operand_b;
   assign dec_if.branch_dest = dec_q.branch_dest;
   assign dec_if.dest        = dec_q.dest;
   assign dec_if.func3       = dec_q.func3;
   assign dec_if.func7       = dec_q.func7;

endmodule

// File: tb/tb_rv32i_instr_decoder.sv
// Table-driven bench for the RV32I decode stage, with a small register-file
// model feeding rdata from the decoder's read addresses.
module tb_rv32i_instr_decoder;

   logic clk = 1'b0;
   logic reset;

   rv32i_instr_decoder_if bus ();

   rv32i_instr_decoder dut (
      .clk    (clk),
      .reset  (reset),
      .dec_if (bus.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] regs [32];

   assign bus.rdata1 = regs[bus.raddr1];
   assign bus.rdata2 = regs[bus.raddr2];

   // flags packed as {store, load, branch, jump, reg, alu}
   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [5:0]  flags;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [31:0] bd;
      logic [4:0]  dest;
      logic [2:0]  f3;
      logic        f7;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input string nm, input logic [31:0] ins,
                               input logic [4:0] ra1, input logic [4:0] ra2,
                               input logic [5:0] fl, input logic [31:0] opa,
                               input logic [31:0] opb, input logic [31:0] bd,
                               input logic [4:0] dest, input logic [2:0] f3,
                               input logic f7);
      vec_t v;
      v.name = nm; v.instr = ins; v.ra1 = ra1; v.ra2 = ra2; v.flags = fl;
      v.opa = opa; v.opb = opb; v.bd = bd; v.dest = dest; v.f3 = f3; v.f7 = f7;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] flags_now();
      return {bus.is_store, bus.is_load, bus.is_branch, bus.is_jump, bus.is_reg, bus.is_alu};
   endfunction

   task automatic chk_regd(input string nm, input vec_t v);
      chk({nm, ".flags"},       {26'd0, flags_now()},      {26'd0, v.flags});
      chk({nm, ".operand_a"},   bus.operand_a,             v.opa);
      chk({nm, ".operand_b"},   bus.operand_b,             v.opb);
      chk({nm, ".branch_dest"}, bus.branch_dest,           v.bd);
      chk({nm, ".dest"},        {27'd0, bus.dest},         {27'd0, v.dest});
      chk({nm, ".func3"},       {29'd0, bus.func3},        {29'd0, v.f3});
      chk({nm, ".func7"},       {31'd0, bus.func7},        {31'd0, v.f7});
   endtask

   task automatic chk_raddr(input string nm, input logic [4:0] e1, input logic [4:0] e2);
      chk({nm, ".raddr1"}, {27'd0, bus.raddr1}, {27'd0, e1});
      chk({nm, ".raddr2"}, {27'd0, bus.raddr2}, {27'd0, e2});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t zero_v;
      vec_t v;

      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[1]  = 32'd111;
      regs[2]  = 32'd222;
      regs[3]  = 32'd5000;
      regs[5]  = 32'd10;
      regs[6]  = 32'h1234_5678;
      regs[14] = 32'd4567;
      regs[15] = 32'd9876;
      regs[27] = 32'hDEAD_BEEF;
      regs[28] = 32'hCAFE_F00D;
      regs[31] = 32'd12345;

      //            name      instr         ra1    ra2    flags      opa            opb            bd             dest   f3      f7
      vecs.push_back(mk("jal",      32'h7D0001EF, 5'd0,  5'd16, 6'b000100, 32'd2000,      32'd0,         32'd0,         5'd3,  3'd0, 1'b0));
      vecs.push_back(mk("jalr",     32'h7D0F8167, 5'd31, 5'd16, 6'b000110, 32'd12345,     32'd2000,      32'd0,         5'd2,  3'd0, 1'b0));
      vecs.push_back(mk("beq",      32'h7CE78863, 5'd15, 5'd14, 6'b001000, 32'd9876,      32'd4567,      32'd2000,      5'd0,  3'd0, 1'b0));
      vecs.push_back(mk("andi",     32'h8302FF93, 5'd5,  5'd16, 6'b000001, 32'd10,        32'hFFFFF830,  32'd0,         5'd31, 3'd7, 1'b0));
      vecs.push_back(mk("srai",     32'h40A1D693, 5'd3,  5'd10, 6'b000001, 32'd5000,      32'd10,        32'd0,         5'd13, 3'd5, 1'b1));
      vecs.push_back(mk("lw_neg",   32'hFFC0A203, 5'd1,  5'd28, 6'b010000, 32'd111,       32'hFFFFFFFC,  32'd0,         5'd4,  3'd2, 1'b0));
      vecs.push_back(mk("sw",       32'h0020A423, 5'd1,  5'd2,  6'b100000, 32'd111,       32'd222,       32'd8,         5'd0,  3'd2, 1'b0));
      vecs.push_back(mk("sb_neg",   32'hFE628FA3, 5'd5,  5'd6,  6'b100000, 32'd10,        32'h12345678,  32'hFFFFFFFF,  5'd0,  3'd0, 1'b0));
      vecs.push_back(mk("sub",      32'h402083B3, 5'd1,  5'd2,  6'b000011, 32'd111,       32'd222,       32'd0,         5'd7,  3'd0, 1'b1));
      vecs.push_back(mk("lui",      32'hABCDE4B7, 5'd27, 5'd28, 6'b000001, 32'd0,         32'hABCDE000,  32'd0,         5'd9,  3'd0, 1'b0));
      vecs.push_back(mk("auipc",    32'h80000517, 5'd0,  5'd0,  6'b000000, 32'h80000000,  32'd0,         32'd0,         5'd10, 3'd0, 1'b0));
      vecs.push_back(mk("unknown",  32'hFFFFFFFF, 5'd31, 5'd31, 6'b000000, 32'd0,         32'd0,         32'd0,         5'd0,  3'd0, 1'b0));
      vecs.push_back(mk("jal_neg",  32'hFFDFF0EF, 5'd31, 5'd29, 6'b000100, 32'hFFFFFFFC,  32'd0,         32'd0,         5'd1,  3'd0, 1'b0));
      vecs.push_back(mk("bne_neg",  32'hFE209CE3, 5'd1,  5'd2,  6'b001000, 32'd111,       32'd222,       32'hFFFFFFF8,  5'd0,  3'd1, 1'b0));
      vecs.push_back(mk("slli31",   32'h01F31413, 5'd6,  5'd31, 6'b000001, 32'h12345678,  32'd31,        32'd0,         5'd8,  3'd1, 1'b0));
      vecs.push_back(mk("addi_b30", 32'h40018593, 5'd3,  5'd0,  6'b000001, 32'd5000,      32'd1024,      32'd0,         5'd11, 3'd0, 1'b0));

      zero_v = mk("zero", 32'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);

      // Reset held across an edge with an all-ones instruction on the bus.
      reset     = 1'b0;
      bus.instr = 32'hFFFFFFFF;
      #1;
      chk_raddr("reset", 5'd0, 5'd0);
      @(posedge clk); #1;
      chk_regd("reset", zero_v);
      chk_raddr("reset_hold", 5'd0, 5'd0);

      // Back-to-back vectors, one per cycle.
      reset = 1'b1;
      foreach (vecs[i]) begin
         v = vecs[i];
         bus.instr = v.instr;
         #1;
         chk_raddr(v.name, v.ra1, v.ra2);
         @(posedge clk); #1;
         chk_regd(v.name, v);
      end

      // Mid-stream reset overrides a valid jalr on the same edge.
      bus.instr = 32'h7D0F8167;
      reset     = 1'b0;
      #1;
      chk_raddr("midrst", 5'd0, 5'd0);
      @(posedge clk); #1;
      chk_regd("midrst", zero_v);

      // Releasing reset with the same instruction held resumes decode next edge.
      reset = 1'b1;
      #1;
      chk_raddr("resume", 5'd31, 5'd16);
      @(posedge clk); #1;
      chk_regd("resume", vecs[1]);

      // Registered results hold their value when the instruction is unchanged.
      @(posedge clk); #1;
      chk_regd("hold", vecs[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
